// File: rtl/classify_ctrl.sv
// Streaming arg-max classifier: buffers one frame of signed scores, scans it
// one compare per cycle, then holds the winning index/value until taken.
module classify_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  res_valid,
    output logic [IDX_WIDTH-1:0]  res_index,
    output logic [DATA_WIDTH-1:0] res_value,
    input  logic                  res_ready,
    output logic                  busy,
    output logic                  err_len,
    output logic [15:0]           frame_cnt,
    output logic [1:0]            dbg_state
);

    // Handshakes: a beat moves on a rising edge where in_valid & in_ready;
    // a result moves on a rising edge where res_valid & res_ready.

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SCAN = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [IDX_WIDTH-1:0]  scan_i_q, scan_i_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  res_valid_q, res_valid_d;
    logic [IDX_WIDTH-1:0]  res_index_q, res_index_d;
    logic [DATA_WIDTH-1:0] res_value_q, res_value_d;
    logic                  err_len_q, err_len_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;

    logic [DATA_WIDTH-1:0] buf_q [NUM_CLASSES];

    logic                  accept;
    logic                  buf_we;
    logic [DATA_WIDTH-1:0] cand;
    logic                  greater;
    logic [DATA_WIDTH-1:0] next_max;
    logic [IDX_WIDTH-1:0]  next_idx;

    assign in_ready  = (state_q == ST_LOAD);
    assign accept    = in_valid && in_ready;
    assign buf_we    = accept && !flush;
    assign cand      = buf_q[scan_i_q];
    // Strict greater-than keeps the lower index on ties.
    assign greater   = $signed(cand) > $signed(max_q);
    assign next_max  = greater ? cand : max_q;
    assign next_idx  = greater ? scan_i_q : idx_q;

    assign res_valid = res_valid_q;
    assign res_index = res_index_q;
    assign res_value = res_value_q;
    assign err_len   = err_len_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != ST_LOAD) || (wr_cnt_q != '0);
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        scan_i_d    = scan_i_q;
        max_d       = max_q;
        idx_d       = idx_q;
        res_valid_d = res_valid_q;
        res_index_d = res_index_q;
        res_value_d = res_value_q;
        err_len_d   = err_len_q;
        frame_cnt_d = frame_cnt_q;

        if (flush) begin
            state_d     = ST_LOAD;
            wr_cnt_d    = '0;
            scan_i_d    = '0;
            res_valid_d = 1'b0;
            err_len_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        if (wr_cnt_q == LAST_IDX) begin
                            state_d  = ST_SCAN;
                            max_d    = buf_q[0];
                            idx_d    = '0;
                            scan_i_d = IDX_WIDTH'(1);
                            wr_cnt_d = '0;
                            if (!in_last) err_len_d = 1'b1;
                        end else if (in_last) begin
                            // Short frame: drop it and wait for a fresh one.
                            err_len_d = 1'b1;
                            wr_cnt_d  = '0;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    max_d = next_max;
                    idx_d = next_idx;
                    if (scan_i_q == LAST_IDX) begin
                        state_d     = ST_OUT;
                        scan_i_d    = '0;
                        res_valid_d = 1'b1;
                        res_index_d = next_idx;
                        res_value_d = next_max;
                    end else begin
                        scan_i_d = scan_i_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        state_d     = ST_LOAD;
                        res_valid_d = 1'b0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            wr_cnt_q    <= '0;
            scan_i_q    <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_value_q <= '0;
            err_len_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            scan_i_q    <= scan_i_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_value_q <= res_value_d;
            err_len_q   <= err_len_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Score storage needs no reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_cnt_q] <= in_data;
    end

endmodule

// File: tb/tb_classify_ctrl.sv
// Directed bench for classify_ctrl: hand-computed frames, result latency,
// back-pressure, length errors, flush and asynchronous reset recovery.
module tb_classify_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        res_valid;
    logic [3:0]  res_index;
    logic [15:0] res_value;
    logic        res_ready;
    logic        busy;
    logic        err_len;
    logic [15:0] frame_cnt;
    logic [1:0]  dbg_state;

    int          num_checks;
    int          num_errors;
    logic [15:0] exp_fc;
    logic [15:0] scores [10];

    classify_ctrl #(
        .DATA_WIDTH (16),
        .NUM_CLASSES(10),
        .IDX_WIDTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .res_valid(res_valid),
        .res_index(res_index),
        .res_value(res_value),
        .res_ready(res_ready),
        .busy     (busy),
        .err_len  (err_len),
        .frame_cnt(frame_cnt),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends nbeats beats from scores[], with in_last on beat last_at (-1: none).
    task automatic send_beats(input int nbeats, input int last_at);
        for (int k = 0; k < nbeats; k++) begin
            in_valid = 1'b1;
            in_data  = scores[k];
            in_last  = (k == last_at);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Called right after the accept edge of the last beat.
    task automatic wait_result(input string tag, input logic [3:0] exp_idx, input logic [15:0] exp_val);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n = i;
            if (res_valid) break;
        end
        check({tag, "_latency"}, n, 9);
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_index"}, res_index, exp_idx);
        check({tag, "_value"}, res_value, exp_val);
        check({tag, "_state_out"}, dbg_state, 2);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_fc = exp_fc + 16'd1;
        check({tag, "_hs_valid"}, res_valid, 0);
        check({tag, "_hs_frame_cnt"}, frame_cnt, exp_fc);
        check({tag, "_hs_in_ready"}, in_ready, 1);
        check({tag, "_hs_busy"}, busy, 0);
    endtask

    initial begin
        logic seen;
        num_checks = 0;
        num_errors = 0;
        exp_fc    = 16'd0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        repeat (2) tick();

        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_index", res_index, 0);
        check("rst_res_value", res_value, 0);
        check("rst_err_len", err_len, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        tick();

        // ascending scores
        for (int k = 0; k < 10; k++) scores[k] = 16'(k);
        send_beats(10, 9);
        check("asc_state_scan", dbg_state, 1);
        check("asc_busy", busy, 1);
        wait_result("asc", 4'd9, 16'h0009);
        check("asc_err_len", err_len, 0);
        handshake("asc");
        check("asc_index_kept", res_index, 9);

        // all equal: lowest index wins
        for (int k = 0; k < 10; k++) scores[k] = 16'h0005;
        send_beats(10, 9);
        wait_result("tie", 4'd0, 16'h0005);
        handshake("tie");

        // negative scores, signed compare
        for (int k = 0; k < 10; k++) scores[k] = 16'hFF9C;
        scores[6] = 16'hFFFF;
        send_beats(10, 9);
        wait_result("neg", 4'd6, 16'hFFFF);
        handshake("neg");

        // back-pressure: hold result 20 cycles while junk beats are offered
        for (int k = 0; k < 10; k++) scores[k] = 16'(100 - 7 * k);
        scores[4] = 16'h0200;
        send_beats(10, 9);
        wait_result("hold", 4'd4, 16'h0200);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h7FFF;
            in_last  = 1'b1;
            tick();
            check("hold_valid", res_valid, 1);
            check("hold_index", res_index, 4);
            check("hold_value", res_value, 16'h0200);
            check("hold_in_ready", in_ready, 0);
            check("hold_frame_cnt", frame_cnt, exp_fc);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake("hold");
        check("hold_err_len", err_len, 0);

        // short frame: in_last on beat 3
        for (int k = 0; k < 10; k++) scores[k] = 16'h0010;
        send_beats(4, 3);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("short_no_result", seen, 0);
        check("short_err_len", err_len, 1);
        check("short_busy", busy, 0);
        check("short_in_ready", in_ready, 1);

        // good frame after error; duplicate max at 7 must lose to 2
        for (int k = 0; k < 10; k++) scores[k] = 16'(k * 3);
        scores[2] = 16'h1234;
        scores[7] = 16'h1234;
        send_beats(10, 9);
        wait_result("after_err", 4'd2, 16'h1234);
        check("after_err_err_len", err_len, 1);
        handshake("after_err");

        // flush in LOAD clears err_len and does not store the offered beat
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h5555;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_err_len", err_len, 0);
        check("flush_busy", busy, 0);
        check("flush_frame_cnt", frame_cnt, exp_fc);

        // missing in_last on final beat: processed but flagged
        for (int k = 0; k < 10; k++) scores[k] = 16'(20 - k);
        send_beats(10, -1);
        check("nolast_err_len", err_len, 1);
        wait_result("nolast", 4'd0, 16'd20);
        handshake("nolast");

        // asynchronous reset mid-scan
        for (int k = 0; k < 10; k++) scores[k] = 16'(k + 1);
        send_beats(10, 9);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        exp_fc = 16'd0;
        check("arst_res_valid", res_valid, 0);
        check("arst_res_index", res_index, 0);
        check("arst_res_value", res_value, 0);
        check("arst_err_len", err_len, 0);
        check("arst_frame_cnt", frame_cnt, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("arst_no_result", seen, 0);

        // flush while a result is waiting
        for (int k = 0; k < 10; k++) scores[k] = 16'(50 + k);
        scores[0] = 16'h0300;
        send_beats(10, 9);
        wait_result("pre_flush", 4'd0, 16'h0300);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7777;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("oflush_res_valid", res_valid, 0);
        check("oflush_in_ready", in_ready, 1);
        check("oflush_busy", busy, 0);
        check("oflush_frame_cnt", frame_cnt, 0);
        check("oflush_res_index_kept", res_index, 0);
        check("oflush_res_value_kept", res_value, 16'h0300);

        // third frame after reset and flush
        for (int k = 0; k < 10; k++) scores[k] = 16'hFF00 + 16'(k);
        scores[8] = 16'h0001;
        send_beats(10, 9);
        wait_result("third", 4'd8, 16'h0001);
        handshake("third");

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
